// File: rtl/score_hs_lives_tracker.sv
// -----------------------------------------------------------------------------
// score_hs_lives_tracker
//
// Sits behind the four-digit BCD score counter. It keeps the session high
// score, awards one extra life per game when the score reaches a BCD threshold,
// and tracks the life count and game-over status for the renderer and the game
// controller.
//
// Parameters
//   EXTRA_LIFE_TH  packed-BCD extra-life threshold {th,hu,te,un}
//   INIT_LIVES     lives loaded at reset and on game_start (1..MAX_LIVES)
//   MAX_LIVES      life-count ceiling (<= 7)
//   BLINK_DIV      cycles per blink half-period (blink build only)
//
// Ports
//   clk                         system clock
//   reset                       synchronous, active-high reset
//   digit_units..digit_thousands  live score digits (valid BCD)
//   game_start                  1-cycle pulse: start / restart a game
//   pacman_died                 1-cycle pulse: one life lost
//   hs_units..hs_thousands      high-score digits
//   new_high                    sticky: high score overwritten this game
//   new_high_blink              display version of new_high
//   extra_life                  1-cycle award pulse
//   lives                       remaining lives
//   game_over                   high while in OVER
//
// Build option
//   SCORE_HS_BLINK_EN  when defined, new_high_blink blinks at BLINK_DIV
//                      cycles per half-period while new_high is set; when
//                      undefined it is a registered copy of new_high.
//
// All outputs come straight from flops; packed BCD compares as plain unsigned.
// -----------------------------------------------------------------------------
module score_hs_lives_tracker #(
    parameter logic [15:0] EXTRA_LIFE_TH = 16'h1000,
    parameter int          INIT_LIVES    = 3,
    parameter int          MAX_LIVES     = 5,
    parameter int          BLINK_DIV     = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_units,
    input  logic [3:0] digit_tens,
    input  logic [3:0] digit_hundreds,
    input  logic [3:0] digit_thousands,
    input  logic       game_start,
    input  logic       pacman_died,
    output logic [3:0] hs_units,
    output logic [3:0] hs_tens,
    output logic [3:0] hs_hundreds,
    output logic [3:0] hs_thousands,
    output logic       new_high,
    output logic       new_high_blink,
    output logic       extra_life,
    output logic [2:0] lives,
    output logic       game_over
);

    localparam logic [2:0]  INIT_L    = 3'(INIT_LIVES);
    localparam logic [2:0]  MAX_L     = 3'(MAX_LIVES);
    localparam logic [15:0] WRAP_HI   = 16'h9980;
    localparam logic [15:0] WRAP_LO   = 16'h0020;
    localparam logic [15:0] HS_MAX    = 16'h9999;

    // Elaboration-time parameter sanity check.
    if (INIT_LIVES < 1 || INIT_LIVES > MAX_LIVES || MAX_LIVES > 7 || BLINK_DIV < 1) begin : g_bad_param
        $error("score_hs_lives_tracker: illegal parameter combination");
    end

    typedef enum logic {PLAYING = 1'b0, OVER = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] score, score_q;
    logic [15:0] hs_q, hs_d;
    logic        nh_q, nh_d;
    logic        wrapped_q, wrapped_d;
    logic        el_done_q, el_done_d;
    logic        el_fire;
    logic        died;
    logic        wrap_det;
    logic        hs_take;
    logic [2:0]  lives_q, lives_d;
    logic        blink_q;

    assign score = {digit_thousands, digit_hundreds, digit_tens, digit_units};

    // A wrap is the counter rolling 9999 -> 0000 while adding points: the
    // previous sample sits near the top and the new one near the bottom.
    // Any other drop (upstream clear) just reloads score_q.
    assign wrap_det = (score_q >= WRAP_HI) && (score < WRAP_LO) && !game_start;

    // After a wrap, hs is pinned at 9999 until the next game.
    assign hs_take  = !wrapped_q && (score > hs_q);

    // game_start outranks both life events.
    assign el_fire  = (state_q == PLAYING) && !el_done_q &&
                      (score >= EXTRA_LIFE_TH) && !game_start;
    assign died     = pacman_died && (state_q == PLAYING) && !game_start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= PLAYING;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (game_start)
            state_d = PLAYING;
        else if (died && !el_fire && lives_q <= 3'd1)
            state_d = OVER;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        game_over = (state_q == OVER);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        lives_d = lives_q;
        if (game_start)
            lives_d = INIT_L;
        else if (died && el_fire)
            lives_d = lives_q;                      // loss and award cancel
        else if (died)
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
        else if (el_fire)
            lives_d = (lives_q >= MAX_L) ? MAX_L : lives_q + 3'd1;
    end

    always_comb begin
        hs_d = hs_q;
        if (wrap_det)
            hs_d = HS_MAX;
        else if (hs_take)
            hs_d = score;
    end

    always_comb begin
        nh_d      = nh_q;
        wrapped_d = wrapped_q;
        el_done_d = el_done_q | el_fire;
        if (game_start) begin
            // A new game clears the per-game flags; hs itself is kept.
            nh_d      = 1'b0;
            wrapped_d = 1'b0;
            el_done_d = 1'b0;
        end else begin
            if (wrap_det || hs_take) nh_d = 1'b1;
            if (wrap_det)            wrapped_d = 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q    <= 16'h0000;
            hs_q       <= 16'h0000;
            nh_q       <= 1'b0;
            wrapped_q  <= 1'b0;
            el_done_q  <= 1'b0;
            extra_life <= 1'b0;
            lives_q    <= INIT_L;
        end else begin
            score_q    <= score;
            hs_q       <= hs_d;
            nh_q       <= nh_d;
            wrapped_q  <= wrapped_d;
            el_done_q  <= el_done_d;
            extra_life <= el_fire;
            lives_q    <= lives_d;
        end
    end

`ifdef SCORE_HS_BLINK_EN
    // Blink counter only runs while new_high is set. The first cycle after
    // new_high rises shows 1; the level then toggles every BLINK_DIV cycles.
    localparam logic [23:0] BLINK_LAST = 24'(BLINK_DIV - 1);
    logic [23:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= 24'd0;
            blink_q   <= 1'b0;
        end else if (!nh_d) begin
            blink_cnt <= 24'd0;
            blink_q   <= 1'b0;
        end else if (!nh_q) begin
            blink_cnt <= 24'd0;
            blink_q   <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= 24'd0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end
`else
    // Registered copy of new_high, same edge, same timing.
    always_ff @(posedge clk) begin
        if (reset) blink_q <= 1'b0;
        else       blink_q <= nh_d;
    end
`endif

    assign {hs_thousands, hs_hundreds, hs_tens, hs_units} = hs_q;
    assign new_high       = nh_q;
    assign new_high_blink = blink_q;
    assign lives          = lives_q;

endmodule

// File: doc/score_hs_lives_tracker.md
# score_hs_lives_tracker

Downstream consumer of the four-digit BCD score counter in the score-board path. Tracks the session high score and awards one extra life per game at a BCD score threshold. Maintains the life count and game-over status. Drives the high-score digits and status flags to the score-board renderer and game controller.

## Interface
- EXTRA_LIFE_TH, 16'h1000: packed-BCD extra-life threshold as {thousands,tens-of...,units}, i.e. 1000 points.
- INIT_LIVES, 3: lives loaded at reset and at game_start (1..MAX_LIVES).
- MAX_LIVES, 5: life-count saturation ceiling (≤7).
- BLINK_DIV, 12_500_000: cycles per blink half-period (used only with SCORE_HS_BLINK_EN).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digit_units / digit_tens / digit_hundreds / digit_thousands  in  4 each  live score from the BCD counter, valid BCD.
- game_start  in  1  one-cycle pulse; starts or restarts a game.
- pacman_died  in  1  one-cycle pulse; one life lost.
- hs_units / hs_tens / hs_hundreds / hs_thousands  out  4 each  high score.
- new_high  out  1  sticky: high score overwritten during this game.
- new_high_blink  out  1  display version of new_high.
- extra_life  out  1  one-cycle award pulse.
- lives  out  3  remaining lives.
- game_over  out  1  high while in OVER state.

## Operation
- Internal packed score S = {thousands,hundreds,tens,units}.
  - Packed-BCD unsigned compare equals decimal compare; all comparisons are 16-bit unsigned.
- Score register score_q samples S every cycle.
- High score:
  - If S > hs and not wrapped: hs ← S and new_high ← 1 on the same edge.
  - Equal is not a new high.
- Wrap detection:
  - Condition: score_q ≥ 16'h9980 and S < 16'h0020, no game_start this cycle.
  - Effect: hs ← 16'h9999, new_high ← 1, sticky wrapped ← 1.
  - While wrapped, hs holds 9999.
  - Any other decrease of S (upstream score reset) is not a wrap: score_q reloads and nothing else happens.
- Extra life:
  - Fires when state PLAYING, el_done = 0, and S ≥ EXTRA_LIFE_TH.
  - Effect: extra_life pulses 1 cycle and el_done ← 1.
  - Fires at most once per game.
  - If lives = MAX_LIVES, the pulse still fires, el_done sets, and lives stays saturated.
- FSM with two states, PLAYING and OVER:
  - PLAYING: pacman_died decrements lives. If the result is 0, go to OVER.
  - OVER: pacman_died is ignored and no extra life is awarded; hs still tracks S.
  - game_start from either state: go to PLAYING; lives ← INIT_LIVES; new_high, el_done and wrapped cleared. hs is kept.
- Simultaneous events:
  - game_start beats pacman_died and extra_life in the same cycle.
  - pacman_died + extra_life in the same cycle: net lives unchanged, no OVER transition.
  - pacman_died when lives = 1 and no extra_life: lives ← 0, OVER.
- Reset values:
  - hs = 0000, new_high = 0, new_high_blink = 0, extra_life = 0.
  - lives = INIT_LIVES, game_over = 0, state PLAYING.
  - el_done = 0, wrapped = 0, score_q = 0000, blink counter = 0.

## Timing
- All outputs are registered; no combinational input-to-output path.
- hs / new_high update 1 cycle after S changes (edge N samples, visible after N).
- extra_life is asserted for exactly the 1 cycle following the edge that samples S ≥ threshold.
- lives / game_over update 1 cycle after pacman_died or game_start.
- reset has priority over all inputs and takes effect on the clk edge where it is sampled high, including mid-blink or mid-game.
- Input pulses longer than 1 cycle are treated as repeated events. Upstream guarantees single-cycle pulses.

## Configuration
- SCORE_HS_BLINK_EN defined:
  - A 24-bit counter runs only while new_high = 1 and is cleared when new_high = 0.
  - new_high_blink toggles each time the counter reaches BLINK_DIV−1.
  - new_high_blink is 1 in the first cycle after new_high rises and 0 whenever new_high = 0.
- Not defined: new_high_blink = new_high (registered copy, same timing); no counter logic.

## Test plan
- Reset, then S = 0150 → next cycle hs = 0150, new_high = 1. Then S = 0150 → no change. Then game_start, S = 0000 → hs = 0150, new_high = 0.
- S steps 0990 → 1000 → extra_life high exactly 1 cycle. Then S = 1010 → no second pulse. After game_start and S crossing 1000 again → one pulse.
- INIT_LIVES = 3: three pacman_died pulses → lives 2, 1, 0, game_over = 1 one cycle after the third pulse. A fourth pulse leaves lives = 0. game_start → lives = 3, game_over = 0.
- lives = 1, pacman_died and extra_life-triggering S = 1000 in the same cycle → lives = 1, game_over = 0. With lives = MAX_LIVES = 5, crossing the threshold → pulse, lives = 5.
- S = 9985 → 0005 → hs = 9999, new_high = 1. Later S = 0500 → hs stays 9999. S = 9500 → 0000 (not a wrap) → hs unchanged.
- With SCORE_HS_BLINK_EN, BLINK_DIV = 4: after a new high, new_high_blink = 1,1,1,1,0,0,0,0,1…. Without the macro, new_high_blink tracks new_high with identical timing.
